alu_sequencer: RTL and testbench



---
 rtl/alu_sequencer.sv | 122 ++++++++++++
 tb/tb_alu_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Sequences the combinational 4-bit ALU from a latched 12-bit instruction word,
// holding a 4x4-bit register file and driving the seven-segment display inputs.
module alu_sequencer (
    input  logic        clk,
    input  logic        rstN,
    input  logic [11:0] in,
    input  logic        start,
    input  logic [3:0]  aluOut,
    input  logic        aluOverFlow,
    output logic [3:0]  aluOpCode,
    output logic [3:0]  aluA,
    output logic [3:0]  aluB,
    output logic [3:0]  dispVal,
    output logic        dispOverFlow,
    output logic        busy,
    output logic        done
);

    // state | meaning
    // IDLE  | waiting for a start rising edge
    // FETCH | drive ALU operands from the register file (mode 00)
    // EXEC  | capture result and overflow
    // WRITE | register write-back, display update, done pulse
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WRITE} state_t;

    localparam logic [1:0] MODE_ALU  = 2'b00;
    localparam logic [1:0] MODE_LDI  = 2'b01;
    localparam logic [1:0] MODE_SHOW = 2'b10;

    state_t      state;
    logic [3:0]  regs [4];
    logic [11:0] instr_reg;
    logic [3:0]  res_reg;
    logic        ovf_reg;
    logic        start_q;
    logic        start_rise;

    logic [1:0]  mode;
    logic [1:0]  rb;
    logic [1:0]  ra;
    logic [1:0]  rd;
    logic [3:0]  opcode;
    logic [3:0]  imm;

    assign mode       = instr_reg[11:10];
    assign rb         = instr_reg[9:8];
    assign ra         = instr_reg[7:6];
    assign rd         = instr_reg[5:4];
    assign opcode     = instr_reg[3:0];
    assign imm        = instr_reg[9:6];
    assign start_rise = start & ~start_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state        <= IDLE;
            for (int i = 0; i < 4; i++) regs[i] <= 4'd0;
            instr_reg    <= 12'd0;
            res_reg      <= 4'd0;
            ovf_reg      <= 1'b0;
            start_q      <= 1'b0;
            aluOpCode    <= 4'd0;
            aluA         <= 4'd0;
            aluB         <= 4'd0;
            dispVal      <= 4'd0;
            dispOverFlow <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        instr_reg <= in;
                        busy      <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    // Other modes leave the ALU inputs untouched so the ALU does not toggle.
                    if (mode == MODE_ALU) begin
                        aluOpCode <= opcode;
                        aluA      <= regs[ra];
                        aluB      <= regs[rb];
                    end
                    state <= EXEC;
                end
                EXEC: begin
                    case (mode)
                        MODE_ALU:  res_reg <= aluOut;
                        MODE_LDI:  res_reg <= imm;
                        MODE_SHOW: res_reg <= regs[ra];
                        default:   res_reg <= res_reg;
                    endcase
                    ovf_reg <= aluOverFlow;
                    state   <= WRITE;
                end
                WRITE: begin
                    case (mode)
                        MODE_ALU: begin
                            regs[rd]     <= res_reg;
                            dispVal      <= res_reg;
                            dispOverFlow <= ovf_reg;
                        end
                        MODE_LDI: begin
                            regs[rd]     <= res_reg;
                            dispVal      <= res_reg;
                            dispOverFlow <= 1'b0;
                        end
                        MODE_SHOW: dispVal <= res_reg;
                        default: ;
                    endcase
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, start abuse,
// mid-instruction reset and randomized instructions against a reference model.
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic [11:0] in_w;
    logic        start_w;
    logic [3:0]  alu_out;
    logic        alu_ovf;
    logic [3:0]  alu_op;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [3:0]  disp_val;
    logic        disp_ovf;
    logic        busy;
    logic        done;
    logic [4:0]  alu_sum;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_regs [4];
    int m_op, m_a, m_b, m_disp, m_ovf;

    typedef struct {
        logic [11:0] instr;
        int          exp_disp;
        int          exp_ovf;
        string       name;
    } vec_t;

    vec_t vecs [8];

    alu_sequencer dut (
        .clk         (clk),
        .rstN        (rst_n),
        .in          (in_w),
        .start       (start_w),
        .aluOut      (alu_out),
        .aluOverFlow (alu_ovf),
        .aluOpCode   (alu_op),
        .aluA        (alu_a),
        .aluB        (alu_b),
        .dispVal     (disp_val),
        .dispOverFlow(disp_ovf),
        .busy        (busy),
        .done        (done)
    );

    // Bench ALU: a + b mod 16, overflow = carry out
    assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_out = alu_sum[3:0];
    assign alu_ovf = alu_sum[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_op = 0; m_a = 0; m_b = 0; m_disp = 0; m_ovf = 0;
    endtask

    task automatic model_apply(input logic [11:0] w);
        int mode, rb, ra, rd, imm, sum;
        mode = int'(w[11:10]);
        rb   = int'(w[9:8]);
        ra   = int'(w[7:6]);
        rd   = int'(w[5:4]);
        imm  = int'(w[9:6]);
        case (mode)
            0: begin
                m_op = int'(w[3:0]);
                m_a  = m_regs[ra];
                m_b  = m_regs[rb];
                sum  = m_a + m_b;
                m_regs[rd] = sum % 16;
                m_disp = sum % 16;
                m_ovf  = (sum > 15) ? 1 : 0;
            end
            1: begin
                m_regs[rd] = imm;
                m_disp = imm;
                m_ovf  = 0;
            end
            2: m_disp = m_regs[ra];
            default: ;
        endcase
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op"},   int'(alu_op),   0);
        check({tag, "_a"},    int'(alu_a),    0);
        check({tag, "_b"},    int'(alu_b),    0);
        check({tag, "_disp"}, int'(disp_val), 0);
        check({tag, "_ovf"},  int'(disp_ovf), 0);
        check({tag, "_busy"}, int'(busy),     0);
        check({tag, "_done"}, int'(done),     0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_instr(input logic [11:0] w, input string tag);
        int busy_n, done_n, done_at;
        model_apply(w);
        in_w    = w;
        start_w = 1'b1;
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start_w = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = k;
            end
            if (k == 1) begin
                check({tag, "_opcode"}, int'(alu_op), m_op);
                check({tag, "_alu_a"},  int'(alu_a),  m_a);
                check({tag, "_alu_b"},  int'(alu_b),  m_b);
            end
            if (k == 3) begin
                check({tag, "_disp"}, int'(disp_val), m_disp);
                check({tag, "_dovf"}, int'(disp_ovf), m_ovf);
            end
        end
        check({tag, "_busy_cycles"}, busy_n, 3);
        check({tag, "_done_pulses"}, done_n, 1);
        check({tag, "_done_at_e3"},  done_at, 3);
    endtask

    initial begin
        int done_n;

        vecs[0] = '{12'h550, 5,  0, "ldi_r1_5"};
        vecs[1] = '{12'h720, 12, 0, "ldi_r2_12"};
        vecs[2] = '{12'h270, 1,  1, "add_r3"};
        vecs[3] = '{12'h840, 5,  1, "show_r1_sticky"};
        vecs[4] = '{12'h8C0, 1,  1, "show_r3"};
        vecs[5] = '{12'hFFF, 1,  1, "nop"};
        vecs[6] = '{12'h550, 5,  0, "ldi_clears_ovf"};
        vecs[7] = '{12'h145, 10, 0, "add_no_carry"};

        // Reset with random inputs
        rst_n   = 1'b0;
        in_w    = 12'($urandom);
        start_w = 1'($urandom_range(0, 1));
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        start_w = 1'b0;
        rst_n   = 1'b1;
        done_n  = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) done_n++;
            if (busy) done_n++;
        end
        check("post_reset_quiet", done_n, 0);

        // Directed vector table
        foreach (vecs[i]) begin
            run_instr(vecs[i].instr, vecs[i].name);
            check({vecs[i].name, "_tbl_disp"}, int'(disp_val), vecs[i].exp_disp);
            check({vecs[i].name, "_tbl_ovf"},  int'(disp_ovf), vecs[i].exp_ovf);
        end

        // Start held high for 20 cycles: a single execution
        in_w    = 12'h4D0;
        start_w = 1'b1;
        done_n  = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        start_w = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_n++;
        end
        model_apply(12'h4D0);
        check("held_start_done_pulses", done_n, 1);
        check("held_start_disp", int'(disp_val), m_disp);

        // Extra start pulses while busy, including one landing in WRITE
        in_w    = 12'h5E0;
        start_w = 1'b1;
        done_n  = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start_w = (k == 0 || k == 2) ? 1'b1 : 1'b0;
            if (done) done_n++;
        end
        model_apply(12'h5E0);
        check("busy_pulses_done", done_n, 1);
        check("busy_pulses_disp", int'(disp_val), m_disp);

        // Randomized instructions
        for (int n = 0; n < 40; n++) begin
            run_instr(12'($urandom_range(0, 4095)), "rand");
        end

        // Reset during EXEC of a mode 00 write to r3
        run_instr(12'h550, "pre_rst_ld1");
        run_instr(12'h720, "pre_rst_ld2");
        in_w    = 12'h270;
        start_w = 1'b1;
        done_n  = 0;
        @(negedge clk);
        start_w = 1'b0;
        @(negedge clk);
        check("midrst_in_exec_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("midrst_no_done", done_n, 0);
        run_instr(12'h8C0, "midrst_show_r3");
        run_instr(12'h550, "midrst_next_ld");
        run_instr(12'h145, "midrst_next_add");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
